// File: rtl/memory_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
//   arb_state_t  : arbiter FSM encoding
//   MASTER_CORE  : grant index of master 0 (multicycle core)
//   MASTER_AUX   : grant index of master 1 (loader / DMA port)
package memory_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESPOND
    } arb_state_t;

    localparam logic MASTER_CORE = 1'b0;
    localparam logic MASTER_AUX  = 1'b1;

endpackage

// File: rtl/memory_bus_arbiter_grant_select.sv
// Combinational winner selection for the memory bus arbiter.
// Build option: define ARBITER_ROUND_ROBIN_EN to alternate simultaneous
// grants; otherwise master 0 always wins a collision.
//   req              in   2  request vector, bit i = master i
//   last_winner      in   1  index of the master granted most recently
//   grant_valid      out  1  at least one master is requesting
//   winner           out  1  index of the master to grant
//   last_winner_next out  1  pointer value to store if this grant is taken
module arbiter_grant_select
    import memory_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic       grant_valid,
    output logic       winner,
    output logic       last_winner_next
);

    always_comb begin
        grant_valid = |req;
        winner      = MASTER_CORE;
`ifdef ARBITER_ROUND_ROBIN_EN
        // A collision goes to whoever did not win last time; a lone
        // requester is granted straight away.
        if (req == 2'b11) begin
            winner = ~last_winner;
        end else if (req[1]) begin
            winner = MASTER_AUX;
        end
`else
        if (!req[0] && req[1]) begin
            winner = MASTER_AUX;
        end
`endif
        last_winner_next = grant_valid ? winner : last_winner;
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares one single-port memory bus between master 0 (core) and master 1
// (loader/DMA). Each access runs IDLE -> ACCESS -> WAIT -> RESPOND -> IDLE;
// the granted master receives a one-cycle ack with read data.
// Build option: ARBITER_ROUND_ROBIN_EN selects round-robin collision
// handling (see arbiter_grant_select); default is fixed priority to m0.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   m{0,1}_req/we/addr/wdata        master request, held until ack
//   m{0,1}_rdata/ack                one-cycle completion and read data
//   mem_read, mem_write             one-cycle memory strobes
//   mem_address, mem_write_data     registered bus, held between accesses
//   mem_read_data                   memory read data, MEM_LATENCY after strobe
//   grant, busy                     bus owner index and in-use flag
module memory_bus_arbiter
    import memory_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ack,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ack,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  grant,
    output logic                  busy
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  grant_q, grant_d;
    logic                  ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  sel_valid;
    logic                  sel_winner;
    logic                  sel_ptr_next;

    arbiter_grant_select u_grant_select (
        .req              ({m1_req, m0_req}),
        .last_winner      (ptr_q),
        .grant_valid      (sel_valid),
        .winner           (sel_winner),
        .last_winner_next (sel_ptr_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            grant_q <= MASTER_CORE;
            ptr_q   <= MASTER_CORE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = ACCESS;
                    grant_d = sel_winner;
                    ptr_d   = sel_ptr_next;
                    if (sel_winner == MASTER_AUX) begin
                        we_d    = m1_we;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                    end else begin
                        we_d    = m0_we;
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                    end
                end
            end
            ACCESS: begin
                cnt_d   = CNT_LOAD;
                state_d = (MEM_LATENCY == 1) ? RESPOND : WAIT;
            end
            WAIT: begin
                // Leave on the decrement that reaches zero, so WAIT lasts
                // MEM_LATENCY-1 cycles and ack lands MEM_LATENCY after the strobe.
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        case (state_q)
            ACCESS: begin
                mem_read  = ~we_q;
                mem_write = we_q;
            end
            RESPOND: begin
                // Read data is passed through only for the granted master and
                // only for the ack cycle, when the memory is guaranteed valid.
                if (grant_q == MASTER_AUX) begin
                    m1_ack = 1'b1;
                    if (!we_q) begin
                        m1_rdata = mem_read_data;
                    end
                end else begin
                    m0_ack = 1'b1;
                    if (!we_q) begin
                        m0_rdata = mem_read_data;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign grant          = grant_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;

endmodule
